// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and mode constants for the gray_counter slice.
// Functions take a 32-bit vector and the active width n; bits at and above n are zero.
package gray_pkg;

  localparam int GRAY_MODE_WRAP = 0;
  localparam int GRAY_MODE_SAT  = 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int n);
    logic [31:0] g;
    g = '0;
    for (int i = 0; i < n - 1; i++) begin
      g[i] = b[i] ^ b[i+1];
    end
    g[n-1] = b[n-1];
    return g;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int n);
    logic [31:0] b;
    b = '0;
    b[n-1] = g[n-1];
    for (int i = n - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter of width N.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] gray,
  output logic [N-1:0] bin
);

  assign bin = N'(gray2bin(32'(gray), N));

endmodule

// File: rtl/gray_counter.sv
// N-bit up/down counter whose primary state is Gray code, with a registered binary shadow.
// Optional self-check (sticky err output) enabled by defining GRAY_COUNTER_CHECK_EN.
module gray_counter
  import gray_pkg::*;
#(
  parameter int          N        = 4,
  parameter int          SATURATE = GRAY_MODE_WRAP,
  parameter logic [31:0] RST_VAL  = 32'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] gray_q,
  output logic [N-1:0] bin_q,
  output logic         tc,
  output logic         wrap_p
`ifdef GRAY_COUNTER_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam logic [N-1:0] MAX_BIN  = '1;
  localparam logic [N-1:0] RST_BIN  = RST_VAL[N-1:0];
  localparam logic [N-1:0] RST_GRAY = N'(bin2gray(32'(RST_BIN), N));

  logic [N-1:0] next_bin;
  logic [N-1:0] next_gray;
  logic [N-1:0] load_gray;
  logic         hold;

  assign tc        = up_dn ? (bin_q == MAX_BIN) : (bin_q == '0);
  assign next_bin  = up_dn ? bin_q + 1'b1 : bin_q - 1'b1;
  assign next_gray = N'(bin2gray(32'(next_bin), N));
  assign load_gray = N'(bin2gray(32'(load_val), N));
  // In saturate mode a step at the terminal count is swallowed rather than wrapping.
  assign hold      = (SATURATE == GRAY_MODE_SAT) && tc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gray_q <= RST_GRAY;
      bin_q  <= RST_BIN;
      wrap_p <= 1'b0;
    end else if (load) begin
      gray_q <= load_gray;
      bin_q  <= load_val;
      wrap_p <= 1'b0;
    end else if (en && !hold) begin
      gray_q <= next_gray;
      bin_q  <= next_bin;
      wrap_p <= tc;
    end else begin
      wrap_p <= 1'b0;
    end
  end

`ifdef GRAY_COUNTER_CHECK_EN
  logic [N-1:0] conv_bin;
  logic [N-1:0] gray_prev;
  logic         step_d;

  gray2bin_conv #(.N(N)) u_conv (
    .gray (gray_q),
    .bin  (conv_bin)
  );

  // step_d marks that the last edge moved the counter, so gray_prev vs gray_q must differ in one bit.
  always_ff @(posedge clk) begin
    gray_prev <= gray_q;
    if (!rst_n) begin
      step_d <= 1'b0;
      err    <= 1'b0;
    end else begin
      step_d <= en && !load && !hold;
      if ((step_d && ($countones(gray_q ^ gray_prev) != 1)) || (conv_bin != bin_q)) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: three 4-bit instances (wrap, saturate, RST_VAL=3)
// sharing one stimulus, plus an 8-bit instance driven randomly against a reference model.
module tb_gray_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] ga, ba, gs, bs, gr, br;
  logic       tca, tcs, tcr, wa, ws, wr;

  logic       rst8_n, e8, u8, l8;
  logic [7:0] lv8, g8, b8, conv8;
  logic       tc8, w8;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

`ifdef GRAY_COUNTER_CHECK_EN
  logic erra, errs, errr, err8;
`endif

  always #5 clk = ~clk;

  gray_counter #(.N(4), .SATURATE(0), .RST_VAL(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .gray_q(ga), .bin_q(ba), .tc(tca), .wrap_p(wa)
`ifdef GRAY_COUNTER_CHECK_EN
    , .err(erra)
`endif
  );

  gray_counter #(.N(4), .SATURATE(1), .RST_VAL(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .gray_q(gs), .bin_q(bs), .tc(tcs), .wrap_p(ws)
`ifdef GRAY_COUNTER_CHECK_EN
    , .err(errs)
`endif
  );

  gray_counter #(.N(4), .SATURATE(0), .RST_VAL(3)) dut_r (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .gray_q(gr), .bin_q(br), .tc(tcr), .wrap_p(wr)
`ifdef GRAY_COUNTER_CHECK_EN
    , .err(errr)
`endif
  );

  gray_counter #(.N(8), .SATURATE(0), .RST_VAL(0)) dut_8 (
    .clk(clk), .rst_n(rst8_n), .en(e8), .up_dn(u8), .load(l8), .load_val(lv8),
    .gray_q(g8), .bin_q(b8), .tc(tc8), .wrap_p(w8)
`ifdef GRAY_COUNTER_CHECK_EN
    , .err(err8)
`endif
  );

  gray2bin_conv #(.N(8)) u_sb_conv (.gray(g8), .bin(conv8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] up_gray [5];
    logic [7:0] m8, pg8;
    logic       mw8, step8;
    up_gray = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};

    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    rst8_n = 1'b0; e8 = 1'b0; u8 = 1'b0; l8 = 1'b0; lv8 = '0;
    tick();
    tick();
    check("rst_gray_a", 32'(ga), 32'h0);
    check("rst_bin_a", 32'(ba), 32'h0);
    check("rst_wrap_a", 32'(wa), 32'h0);
    check("rst_gray_r", 32'(gr), 32'b0010);
    check("rst_bin_r", 32'(br), 32'd3);
    check("rst_gray_8", 32'(g8), 32'h0);

    // count up 5 steps
    rst_n = 1'b1; rst8_n = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("up_gray", 32'(ga), 32'(up_gray[k]));
      check("up_bin", 32'(ba), 32'(k + 1));
      check("up_wrap", 32'(wa), 32'h0);
    end

    // load max then wrap upward
    en = 1'b0; load = 1'b1; load_val = 4'd15;
    tick();
    check("ld15_gray", 32'(ga), 32'b1000);
    check("ld15_bin", 32'(ba), 32'd15);
    check("ld15_tc", 32'(tca), 32'h1);
    load = 1'b0; en = 1'b1;
    tick();
    check("wrapup_gray", 32'(ga), 32'h0);
    check("wrapup_bin", 32'(ba), 32'h0);
    check("wrapup_pulse", 32'(wa), 32'h1);
    check("satup_bin", 32'(bs), 32'd15);
    check("satup_gray", 32'(gs), 32'b1000);
    check("satup_wrap", 32'(ws), 32'h0);
    en = 1'b0;
    tick();
    check("wrapup_pulse_end", 32'(wa), 32'h0);
    check("wrapup_hold", 32'(ga), 32'h0);

    // down step from zero
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; up_dn = 1'b0;
    #1;
    check("dn_tc_a", 32'(tca), 32'h1);
    check("dn_tc_s", 32'(tcs), 32'h1);
    en = 1'b1;
    tick();
    check("wrapdn_gray", 32'(ga), 32'b1000);
    check("wrapdn_bin", 32'(ba), 32'd15);
    check("wrapdn_pulse", 32'(wa), 32'h1);
    check("satdn_gray", 32'(gs), 32'h0);
    check("satdn_bin", 32'(bs), 32'h0);
    check("satdn_wrap", 32'(ws), 32'h0);
    en = 1'b0;
    tick();
    check("wrapdn_pulse_end", 32'(wa), 32'h0);
    check("wrapdn_hold", 32'(ba), 32'd15);

    // load beats enable
    load = 1'b1; load_val = 4'd9; en = 1'b1; up_dn = 1'b1;
    tick();
    check("ldpri_gray", 32'(ga), 32'b1101);
    check("ldpri_bin", 32'(ba), 32'd9);
    check("ldpri_wrap", 32'(wa), 32'h0);

    // reset mid-count overrides load and enable
    load_val = 4'd4; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    tick();
    check("r_at6_bin", 32'(br), 32'd6);
    check("r_at6_gray", 32'(gr), 32'b0101);
    rst_n = 1'b0; load = 1'b1; load_val = 4'd9;
    tick();
    check("rmid_gray", 32'(gr), 32'b0010);
    check("rmid_bin", 32'(br), 32'd3);
    check("rmid_wrap", 32'(wr), 32'h0);
    rst_n = 1'b1; load = 1'b0;
    tick();
    check("resume_bin", 32'(br), 32'd4);
    check("resume_gray", 32'(gr), 32'b0110);
    en = 1'b0;
`ifdef GRAY_COUNTER_CHECK_EN
    check("err_a", 32'(erra), 32'h0);
    check("err_s", 32'(errs), 32'h0);
    check("err_r", 32'(errr), 32'h0);
`endif

    // 8-bit random run against a reference model
    m8 = 8'h0;
    for (int c = 0; c < 10000; c++) begin
      e8  = ($urandom_range(0, 3) != 0);
      u8  = 1'($urandom_range(0, 1));
      l8  = ($urandom_range(0, 15) == 0);
      lv8 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) != 0) ? 8'hff : 8'h00)
                                          : 8'($urandom_range(0, 255));
      #1;
      check("tc8", 32'(tc8), 32'((u8 && m8 == 8'hff) || (!u8 && m8 == 8'h00)));
      mw8   = 1'b0;
      step8 = 1'b0;
      if (l8) begin
        m8 = lv8;
      end else if (e8) begin
        mw8   = (u8 && m8 == 8'hff) || (!u8 && m8 == 8'h00);
        m8    = u8 ? m8 + 8'd1 : m8 - 8'd1;
        step8 = 1'b1;
      end
      exp_q.push_back(32'(m8));
      pg8 = g8;
      tick();
      begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("bin8", 32'(b8), e);
        check("conv8", 32'(conv8), e);
        check("gray8", 32'(g8), e ^ (e >> 1));
      end
      check("wrap8", 32'(w8), 32'(mw8));
      if (step8) check("hamming8", 32'($countones(g8 ^ pg8)), 32'd1);
`ifdef GRAY_COUNTER_CHECK_EN
      check("err8", 32'(err8), 32'h0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
